// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop) from a raw, asynchronous PS/2 clock/data pair and queues each good
// scan code in a first-word-fall-through FIFO. Bytes are queued as they
// arrive; break (0xF0) and extended (0xE0) prefixes are not interpreted.
//
// Parameters
//   FIFO_DEPTH     : scan-code FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES : clk cycles without a ps2_clk fall before an open frame
//                    is abandoned
//
// Ports
//   clk, rst    : system clock, asynchronous active-high reset
//   ps2_clk     : raw PS/2 clock (asynchronous)
//   ps2_data    : raw PS/2 data (asynchronous)
//   code        : head-of-FIFO scan code (0 while empty)
//   code_valid  : FIFO non-empty
//   code_ready  : consumer takes the head entry this cycle
//   count       : FIFO occupancy
//   frame_err   : one-cycle pulse on parity, stop-bit or timeout error
//   overflow    : sticky, a good frame was dropped because the FIFO was full
//   clr_ovf     : clears overflow (a new overflow in the same cycle wins)
module ps2_scan_rx #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    code,
   output logic                          code_valid,
   input  logic                          code_ready,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          frame_err,
   output logic                          overflow,
   input  logic                          clr_ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE, RECV} state_t;

   state_t          state;
   logic [3:0]      bit_cnt;
   logic [8:0]      shift_reg;
   logic [TW-1:0]   idle_cnt;

   logic            clk_s1, clk_s2, clk_s3;
   logic            data_s1, data_s2;
   logic            fall;

   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [7:0]      mem [FIFO_DEPTH];
   logic            full, empty;
   logic            eval, good, timeout, push, pop;

   // Two-flop synchronisers on both PS/2 lines plus a third clock flop for
   // edge detection. Reset to 1 because an idle PS/2 bus floats high, so
   // leaving reset never looks like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         clk_s3  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         clk_s3  <= clk_s2;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

   assign fall = clk_s3 & ~clk_s2;

   // The stop-bit fall is the evaluation point. After nine shifts the data
   // byte sits in shift_reg[7:0] and the parity bit in shift_reg[8], so odd
   // parity means the 9-bit XOR is 1. The stop bit is taken straight from
   // the synchronised data line.
   assign eval    = (state == RECV) && fall && (bit_cnt == 4'd9);
   assign good    = eval && (^shift_reg) && data_s2;
   assign timeout = (state == RECV) && !fall &&
                    (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Frame receiver. IDLE waits for a start bit (data low on a fall); RECV
   // shifts data and parity in, evaluates on the stop bit, and gives up if
   // the keyboard stops clocking for TIMEOUT_CYCLES.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         idle_cnt  <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (fall && !data_s2) begin
                  state     <= RECV;
                  bit_cnt   <= '0;
                  shift_reg <= '0;
               end
            end
            RECV: begin
               if (fall) begin
                  idle_cnt <= '0;
                  if (bit_cnt == 4'd9) begin
                     state     <= IDLE;
                     frame_err <= ~good;
                  end else begin
                     shift_reg <= {data_s2, shift_reg[8:1]};
                     bit_cnt   <= bit_cnt + 4'd1;
                  end
               end else if (timeout) begin
                  state     <= IDLE;
                  frame_err <= 1'b1;
                  idle_cnt  <= '0;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO flags. Pointers carry one extra wrap bit so full and empty are
   // distinguishable when the index bits match. A pop in the same cycle
   // frees a slot, so a full FIFO can still take a push then.
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = !empty && code_ready;
   assign push       = good && (!full || pop);
   assign code_valid = !empty;
   assign count      = wr_ptr - rd_ptr;

   // The memory itself is not reset, so the head is masked to 0 while empty
   // to keep code from showing X before the first write.
   assign code = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

   // Pointer updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage write; no reset needed since reads are masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= shift_reg[7:0];
   end

   // Sticky overflow. Setting takes priority over a simultaneous clear so a
   // drop is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (good && full && !pop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

endmodule
